// File: rtl/rob_pkg.sv
// Shared reorder-buffer sizing and entry layout used by the retire unit and its selector.
package rob_pkg;

  localparam int unsigned ROB_DEPTH = 16;
  localparam int unsigned ROB_IDX_W = 4;
  localparam int unsigned ROB_CNT_W = 5;
  localparam int unsigned PHYS_REGS = 64;
  localparam int unsigned PREG_W    = 6;

  typedef struct packed {
    logic              valid;
    logic              done;
    logic              has_dest;
    logic [PREG_W-1:0] new_rd;
    logic [PREG_W-1:0] old_rd;
  } rob_entry_t;

endpackage

// File: rtl/retire_select.sv
// Picks up to two in-order retiring entries starting at head and builds the physical-register
// release mask for them.
module retire_select
  import rob_pkg::*;
(
  input  rob_entry_t                 entries [ROB_DEPTH],
  input  logic       [ROB_IDX_W-1:0] head,
  output logic                       ret_0,
  output logic                       ret_1,
  output logic       [1:0]           ret_cnt,
  output logic       [PHYS_REGS-1:0] free_mask
);

  logic [ROB_IDX_W-1:0] head_nxt;
  rob_entry_t           e0;
  rob_entry_t           e1;
  logic                 unused_new_rd;

  assign head_nxt      = head + ROB_IDX_W'(1);
  assign e0            = entries[head];
  assign e1            = entries[head_nxt];
  assign unused_new_rd = ^{e0.new_rd, e1.new_rd};

  always_comb begin
    ret_0     = e0.valid & e0.done;
    // Second slot only retires behind the first, keeping retirement in order.
    ret_1     = ret_0 & e1.valid & e1.done;
    ret_cnt   = {1'b0, ret_0} + {1'b0, ret_1};
    free_mask = '0;
    if (ret_0 && e0.has_dest) free_mask[e0.old_rd] = 1'b1;
    if (ret_1 && e1.has_dest) free_mask[e1.old_rd] = 1'b1;
  end

endmodule

// File: rtl/retire_unit.sv
// 16-entry reorder buffer: dual-slot allocation, dual completion ports, and up to two in-order
// retirements per cycle that release old physical mappings.
module retire_unit
  import rob_pkg::*;
(
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 alloc_valid_1,
  input  logic                 alloc_valid_2,
  input  logic                 alloc_has_dest_1,
  input  logic                 alloc_has_dest_2,
  input  logic [PREG_W-1:0]    alloc_new_rd_1,
  input  logic [PREG_W-1:0]    alloc_new_rd_2,
  input  logic [PREG_W-1:0]    alloc_old_rd_1,
  input  logic [PREG_W-1:0]    alloc_old_rd_2,
  output logic [ROB_IDX_W-1:0] rob_idx_1,
  output logic [ROB_IDX_W-1:0] rob_idx_2,
  output logic                 rob_full,
  output logic                 rob_empty,
  input  logic                 cmpl_valid_a,
  input  logic                 cmpl_valid_b,
  input  logic [ROB_IDX_W-1:0] cmpl_idx_a,
  input  logic [ROB_IDX_W-1:0] cmpl_idx_b,
  output logic [PHYS_REGS-1:0] free_regs,
  output logic [1:0]           retire_cnt
);

  rob_entry_t           entries_q [ROB_DEPTH];
  rob_entry_t           entries_d [ROB_DEPTH];
  logic [ROB_IDX_W-1:0] head_q, head_d, tail_q, tail_d, head_nxt;
  logic [ROB_CNT_W-1:0] count_q, count_d;
  logic                 ret_0, ret_1;
  logic [1:0]           ret_cnt;
  logic [PHYS_REGS-1:0] free_mask;
  logic                 do_alloc_1, do_alloc_2;
  logic [1:0]           alloc_cnt;

  // Full means fewer than two free entries, so a dual allocation always fits.
  assign rob_full   = count_q >= ROB_CNT_W'(ROB_DEPTH - 1);
  assign rob_empty  = count_q == '0;
  assign rob_idx_1  = tail_q;
  assign rob_idx_2  = alloc_valid_1 ? tail_q + ROB_IDX_W'(1) : tail_q;
  assign do_alloc_1 = alloc_valid_1 & ~rob_full;
  assign do_alloc_2 = alloc_valid_2 & ~rob_full;
  assign alloc_cnt  = {1'b0, do_alloc_1} + {1'b0, do_alloc_2};
  assign head_nxt   = head_q + ROB_IDX_W'(1);

  retire_select u_retire_select (
    .entries   (entries_q),
    .head      (head_q),
    .ret_0     (ret_0),
    .ret_1     (ret_1),
    .ret_cnt   (ret_cnt),
    .free_mask (free_mask)
  );

  always_comb begin
    entries_d = entries_q;
    if (cmpl_valid_a && entries_q[cmpl_idx_a].valid) entries_d[cmpl_idx_a].done = 1'b1;
    if (cmpl_valid_b && entries_q[cmpl_idx_b].valid) entries_d[cmpl_idx_b].done = 1'b1;
    if (ret_0) begin
      entries_d[head_q].valid = 1'b0;
      entries_d[head_q].done  = 1'b0;
    end
    if (ret_1) begin
      entries_d[head_nxt].valid = 1'b0;
      entries_d[head_nxt].done  = 1'b0;
    end
    if (do_alloc_1) begin
      entries_d[rob_idx_1] = '{valid: 1'b1, done: 1'b0, has_dest: alloc_has_dest_1,
                               new_rd: alloc_new_rd_1, old_rd: alloc_old_rd_1};
    end
    if (do_alloc_2) begin
      entries_d[rob_idx_2] = '{valid: 1'b1, done: 1'b0, has_dest: alloc_has_dest_2,
                               new_rd: alloc_new_rd_2, old_rd: alloc_old_rd_2};
    end
    head_d  = head_q + ROB_IDX_W'(ret_cnt);
    tail_d  = tail_q + ROB_IDX_W'(alloc_cnt);
    count_d = count_q + ROB_CNT_W'(alloc_cnt) - ROB_CNT_W'(ret_cnt);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      entries_q  <= '{default: '0};
      head_q     <= '0;
      tail_q     <= '0;
      count_q    <= '0;
      free_regs  <= '0;
      retire_cnt <= '0;
    end else begin
      entries_q  <= entries_d;
      head_q     <= head_d;
      tail_q     <= tail_d;
      count_q    <= count_d;
      free_regs  <= free_mask;
      retire_cnt <= ret_cnt;
    end
  end

endmodule

// File: tb/tb_retire_unit.sv
// Directed bench for retire_unit with an in-order queue model checked every cycle.
module tb_retire_unit;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        alloc_valid_1, alloc_valid_2, alloc_has_dest_1, alloc_has_dest_2;
  logic [5:0]  alloc_new_rd_1, alloc_new_rd_2, alloc_old_rd_1, alloc_old_rd_2;
  logic [3:0]  rob_idx_1, rob_idx_2;
  logic        rob_full, rob_empty;
  logic        cmpl_valid_a, cmpl_valid_b;
  logic [3:0]  cmpl_idx_a, cmpl_idx_b;
  logic [63:0] free_regs;
  logic [1:0]  retire_cnt;

  int errors = 0;
  int checks = 0;

  retire_unit dut (
    .clk              (clk),
    .reset            (reset),
    .alloc_valid_1    (alloc_valid_1),
    .alloc_valid_2    (alloc_valid_2),
    .alloc_has_dest_1 (alloc_has_dest_1),
    .alloc_has_dest_2 (alloc_has_dest_2),
    .alloc_new_rd_1   (alloc_new_rd_1),
    .alloc_new_rd_2   (alloc_new_rd_2),
    .alloc_old_rd_1   (alloc_old_rd_1),
    .alloc_old_rd_2   (alloc_old_rd_2),
    .rob_idx_1        (rob_idx_1),
    .rob_idx_2        (rob_idx_2),
    .rob_full         (rob_full),
    .rob_empty        (rob_empty),
    .cmpl_valid_a     (cmpl_valid_a),
    .cmpl_valid_b     (cmpl_valid_b),
    .cmpl_idx_a       (cmpl_idx_a),
    .cmpl_idx_b       (cmpl_idx_b),
    .free_regs        (free_regs),
    .retire_cnt       (retire_cnt)
  );

  initial forever #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL timeout: simulation did not finish, errors=%0d", errors);
    $fatal(1);
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, want 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Model: program-order queue of in-flight instructions; indices derived from head + size.
  typedef struct {
    int idx;
    bit done;
    bit has_dest;
    int old_rd;
  } ment_t;

  ment_t       mq[$];
  int          m_head = 0;
  logic [63:0] m_free = '0;
  int          m_cnt = 0;

  function automatic int m_tail();
    return (m_head + mq.size()) % 16;
  endfunction

  task automatic model_edge();
    int          n;
    int          t;
    bit          full;
    logic [63:0] mask;
    ment_t       e;
    if (reset) begin
      mq.delete();
      m_head = 0;
      m_free = '0;
      m_cnt  = 0;
      return;
    end
    n = 0;
    while (n < 2 && n < mq.size() && mq[n].done) n++;
    mask = '0;
    for (int k = 0; k < n; k++) if (mq[k].has_dest) mask[mq[k].old_rd] = 1'b1;
    full = mq.size() >= 15;
    foreach (mq[k]) begin
      if (cmpl_valid_a && mq[k].idx == int'(cmpl_idx_a)) mq[k].done = 1'b1;
      if (cmpl_valid_b && mq[k].idx == int'(cmpl_idx_b)) mq[k].done = 1'b1;
    end
    repeat (n) void'(mq.pop_front());
    m_head = (m_head + n) % 16;
    if (!full) begin
      t = m_tail();
      if (alloc_valid_1) begin
        e = '{idx: t, done: 1'b0, has_dest: alloc_has_dest_1, old_rd: int'(alloc_old_rd_1)};
        mq.push_back(e);
        t = (t + 1) % 16;
      end
      if (alloc_valid_2) begin
        e = '{idx: t, done: 1'b0, has_dest: alloc_has_dest_2, old_rd: int'(alloc_old_rd_2)};
        mq.push_back(e);
      end
    end
    m_free = mask;
    m_cnt  = n;
  endtask

  initial forever begin
    @(posedge clk or posedge reset);
    model_edge();
  end

  initial forever begin
    @(negedge clk);
    check("idx1", {60'd0, rob_idx_1}, 64'(m_tail()));
    check("idx2", {60'd0, rob_idx_2}, 64'((m_tail() + (alloc_valid_1 ? 1 : 0)) % 16));
    check("full", {63'd0, rob_full}, 64'(mq.size() >= 15));
    check("empty", {63'd0, rob_empty}, 64'(mq.size() == 0));
    check("free_regs", free_regs, m_free);
    check("retire_cnt", {62'd0, retire_cnt}, 64'(m_cnt));
  end

  task automatic idle();
    alloc_valid_1 = 0; alloc_valid_2 = 0; alloc_has_dest_1 = 0; alloc_has_dest_2 = 0;
    alloc_new_rd_1 = '0; alloc_new_rd_2 = '0; alloc_old_rd_1 = '0; alloc_old_rd_2 = '0;
    cmpl_valid_a = 0; cmpl_valid_b = 0; cmpl_idx_a = '0; cmpl_idx_b = '0;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    idle();
    #1;
  endtask

  task automatic alloc1(input bit d, input int nr, input int orr);
    alloc_valid_1 = 1; alloc_has_dest_1 = d; alloc_new_rd_1 = 6'(nr); alloc_old_rd_1 = 6'(orr);
  endtask

  task automatic alloc2(input bit d, input int nr, input int orr);
    alloc_valid_2 = 1; alloc_has_dest_2 = d; alloc_new_rd_2 = 6'(nr); alloc_old_rd_2 = 6'(orr);
  endtask

  task automatic cmpl(input bit va, input int ia, input bit vb, input int ib);
    cmpl_valid_a = va; cmpl_idx_a = 4'(ia); cmpl_valid_b = vb; cmpl_idx_b = 4'(ib);
  endtask

  int t;

  initial begin
    idle();
    repeat (2) @(posedge clk);
    #1 reset = 0;
    #1;
    check("rst_empty", {63'd0, rob_empty}, 64'd1);
    check("rst_full", {63'd0, rob_full}, 64'd0);
    check("rst_free", free_regs, 64'd0);
    check("rst_cnt", {62'd0, retire_cnt}, 64'd0);

    // Basic dual alloc, dual complete, dual retire.
    alloc1(1, 32, 5); alloc2(1, 33, 6);
    #1;
    check("first_idx1", {60'd0, rob_idx_1}, 64'd0);
    check("first_idx2", {60'd0, rob_idx_2}, 64'd1);
    step();
    cmpl(1, 0, 1, 1);
    step();
    step();
    check("pair_cnt", {62'd0, retire_cnt}, 64'd2);
    check("pair_free", free_regs, 64'h60);
    step();
    check("pulse_clear_free", free_regs, 64'd0);
    check("pulse_clear_cnt", {62'd0, retire_cnt}, 64'd0);

    // Younger completes first: nothing retires until head completes.
    alloc1(1, 40, 7); alloc2(1, 41, 8);
    step();
    cmpl(0, 0, 1, 3);
    step();
    step();
    check("ooo_hold", {62'd0, retire_cnt}, 64'd0);
    step();
    check("ooo_hold2", {62'd0, retire_cnt}, 64'd0);
    cmpl(1, 2, 0, 0);
    step();
    step();
    check("ooo_cnt", {62'd0, retire_cnt}, 64'd2);
    check("ooo_free", free_regs, 64'h180);

    // Store with no destination.
    alloc1(0, 0, 0);
    #1;
    check("sw_idx", {60'd0, rob_idx_1}, 64'd4);
    step();
    cmpl(1, 4, 0, 0);
    step();
    step();
    check("sw_cnt", {62'd0, retire_cnt}, 64'd1);
    check("sw_free", free_regs, 64'd0);

    // Fill to 15 entries starting at index 5.
    for (int i = 0; i < 7; i++) begin
      alloc1(1, i * 2, 10 + i * 2); alloc2(1, i * 2 + 1, 11 + i * 2);
      step();
    end
    alloc1(1, 20, 24);
    step();
    check("fill_full", {63'd0, rob_full}, 64'd1);
    check("fill_tail", {60'd0, rob_idx_1}, 64'd4);
    alloc1(1, 60, 60); alloc2(1, 61, 61);
    step();
    check("full_ignored_tail", {60'd0, rob_idx_1}, 64'd4);
    check("full_ignored_full", {63'd0, rob_full}, 64'd1);
    cmpl(1, 5, 0, 0);
    step();
    check("full_before_retire", {63'd0, rob_full}, 64'd1);
    step();
    check("full_after_retire", {63'd0, rob_full}, 64'd0);
    check("full_retire_free", free_regs, 64'd1 << 10);
    for (int i = 0; i < 7; i++) begin
      cmpl(1, (6 + 2 * i) % 16, 1, (7 + 2 * i) % 16);
      step();
    end
    repeat (8) step();
    check("drain_empty", {63'd0, rob_empty}, 64'd1);

    // 40 pipelined pairs wrapping the ring several times.
    t = 4;
    for (int i = 0; i < 40; i++) begin
      alloc1(i % 3 != 0, i, (i * 7) % 64); alloc2(1, i + 1, (i * 7 + 3) % 64);
      if (i > 0) cmpl(1, (t + 14) % 16, 1, (t + 15) % 16);
      step();
      t = (t + 2) % 16;
    end
    cmpl(1, (t + 14) % 16, 1, (t + 15) % 16);
    step();
    repeat (3) step();
    check("wrap_empty", {63'd0, rob_empty}, 64'd1);
    check("wrap_tail", {60'd0, rob_idx_1}, 64'd4);

    // Completion on an invalid index must not leak into a later allocation there.
    alloc1(1, 50, 20);
    cmpl(0, 0, 1, 5);
    step();
    alloc1(1, 51, 21);
    cmpl(1, 4, 0, 0);
    step();
    step();
    check("inv_cmpl_cnt", {62'd0, retire_cnt}, 64'd1);
    check("inv_cmpl_free", free_regs, 64'd1 << 20);
    cmpl(1, 5, 1, 5);
    step();
    step();
    check("same_idx_cnt", {62'd0, retire_cnt}, 64'd1);
    check("same_idx_free", free_regs, 64'd1 << 21);

    // Reset with 8 in flight, two of them about to retire.
    for (int k = 0; k < 4; k++) begin
      alloc1(1, 2 * k, 30 + 2 * k); alloc2(1, 2 * k + 1, 31 + 2 * k);
      step();
    end
    cmpl(1, 6, 1, 7);
    step();
    #1 reset = 1;
    #1;
    check("async_empty", {63'd0, rob_empty}, 64'd1);
    check("async_full", {63'd0, rob_full}, 64'd0);
    check("async_free", free_regs, 64'd0);
    @(posedge clk);
    #1;
    check("async_free_edge", free_regs, 64'd0);
    check("async_cnt_edge", {62'd0, retire_cnt}, 64'd0);
    reset = 0;
    step();
    check("post_rst_idx", {60'd0, rob_idx_1}, 64'd0);
    repeat (2) step();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
